// File: rtl/rotary_decoder_if.sv
// Quadrature-encoder bus: raw phases and controls into the decoder, position and status out.
interface rotary_decoder_if #(
    parameter int WIDTH = 8
);
    logic             a;
    logic             b;
    logic             wrap;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clear_err;
    logic [WIDTH-1:0] value;
    logic             step_up;
    logic             step_dn;
    logic             err;

    modport master (
        output a, b, wrap, load, load_value, clear_err,
        input  value, step_up, step_dn, err
    );

    modport slave (
        input  a, b, wrap, load, load_value, clear_err,
        output value, step_up, step_dn, err
    );
endinterface

// File: rtl/rotary_decoder.sv
// Debounced quadrature decoder with wrap/saturate position counter.
// Optional speed-dependent step size enabled by defining ROTARY_DECODER_ACCEL_EN.
module rotary_decoder #(
    parameter int WIDTH    = 8,
    parameter int DECODE   = 4,
    parameter int DEBOUNCE = 4,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = (1 << WIDTH) - 1
`ifdef ROTARY_DECODER_ACCEL_EN
    ,
    parameter int ACCEL_WINDOW = 64,
    parameter int ACCEL_STEP   = 4
`endif
) (
    input  logic            clk,
    input  logic            reset,
    rotary_decoder_if.slave bus
);

    // Two extra bits keep limit + step comparisons free of overflow.
    localparam int XW  = WIDTH + 2;
    localparam int DBW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [XW-1:0] MIN_X = XW'(MIN_VAL);
    localparam logic [XW-1:0] MAX_X = XW'(MAX_VAL);

    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       filt_r;
    logic [1:0]       prev_r;
    logic [WIDTH-1:0] value_r;
    logic             step_up_r;
    logic             step_dn_r;
    logic             err_r;

    logic             up_s;
    logic             dn_s;
    logic             illegal_s;
    logic             cnt_up_s;
    logic             cnt_dn_s;
    logic [XW-1:0]    step_s;
    logic [XW-1:0]    cur_x_s;
    logic [XW-1:0]    sum_x_s;
    logic [XW-1:0]    diff_x_s;
    logic [WIDTH-1:0] nxt_up_s;
    logic [WIDTH-1:0] nxt_dn_s;

    // Two-flop synchroniser for the raw {a,b} phases
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {bus.a, bus.b};
            sync2_r <= sync1_r;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            // Filter bypassed: filtered level is one register behind the synchroniser
            always_ff @(posedge clk) begin
                if (reset) begin
                    filt_r <= 2'b00;
                end else begin
                    filt_r <= sync2_r;
                end
            end
        end else begin : g_filter
            logic [DBW-1:0] db_cnt_r [2];

            // Per-phase debounce: accept a new level only after it has persisted
            always_ff @(posedge clk) begin
                if (reset) begin
                    filt_r      <= 2'b00;
                    db_cnt_r[0] <= '0;
                    db_cnt_r[1] <= '0;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if (sync2_r[i] == filt_r[i]) begin
                            db_cnt_r[i] <= '0;
                        end else if (db_cnt_r[i] == DBW'(DEBOUNCE)) begin
                            filt_r[i]   <= sync2_r[i];
                            db_cnt_r[i] <= '0;
                        end else begin
                            db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // Transition classification and decode-rate selection
    always_comb begin
        up_s      = 1'b0;
        dn_s      = 1'b0;
        cnt_up_s  = 1'b0;
        cnt_dn_s  = 1'b0;
        illegal_s = ((prev_r ^ filt_r) == 2'b11);
        case ({prev_r, filt_r})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up_s = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dn_s = 1'b1;
            default: begin
                up_s = 1'b0;
                dn_s = 1'b0;
            end
        endcase
        if (DECODE == 4) begin
            cnt_up_s = up_s;
            cnt_dn_s = dn_s;
        end else if (DECODE == 2) begin
            cnt_up_s = up_s & (prev_r[1] ^ filt_r[1]);
            cnt_dn_s = dn_s & (prev_r[1] ^ filt_r[1]);
        end else begin
            cnt_up_s = ({prev_r, filt_r} == 4'b00_10);
            cnt_dn_s = ({prev_r, filt_r} == 4'b10_00);
        end
    end

`ifdef ROTARY_DECODER_ACCEL_EN
    localparam int AIW = $clog2(ACCEL_WINDOW + 1);
    localparam logic [AIW-1:0] WIN_MAX  = AIW'(ACCEL_WINDOW);
    localparam logic [AIW-1:0] WIN_LAST = AIW'(ACCEL_WINDOW - 1);

    logic [AIW-1:0] ival_r;
    logic           have_prev_r;
    logic           accepted_s;

    assign accepted_s = (cnt_up_s | cnt_dn_s) & ~bus.load;
    // ival_r holds (cycles since last accepted count) - 1, so fast means interval < window.
    assign step_s     = (have_prev_r && (ival_r < WIN_LAST)) ? XW'(ACCEL_STEP) : XW'(1);

    // Interval since the previous accepted count, saturating at the window
    always_ff @(posedge clk) begin
        if (reset) begin
            ival_r      <= '0;
            have_prev_r <= 1'b0;
        end else if (accepted_s) begin
            ival_r      <= '0;
            have_prev_r <= 1'b1;
        end else if (ival_r != WIN_MAX) begin
            ival_r <= ival_r + 1'b1;
        end else begin
            ival_r <= ival_r;
        end
    end
`else
    assign step_s = XW'(1);
`endif

    assign cur_x_s  = XW'(value_r);
    assign sum_x_s  = cur_x_s + step_s;
    assign diff_x_s = cur_x_s - step_s;

    // Next position for an up or down count under wrap or clamp rules
    always_comb begin
        nxt_up_s = sum_x_s[WIDTH-1:0];
        nxt_dn_s = diff_x_s[WIDTH-1:0];
        if (bus.wrap) begin
            nxt_up_s = sum_x_s[WIDTH-1:0];
            nxt_dn_s = diff_x_s[WIDTH-1:0];
        end else begin
            if (sum_x_s > MAX_X) begin
                nxt_up_s = MAX_X[WIDTH-1:0];
            end else begin
                nxt_up_s = sum_x_s[WIDTH-1:0];
            end
            if (cur_x_s < (MIN_X + step_s)) begin
                nxt_dn_s = MIN_X[WIDTH-1:0];
            end else begin
                nxt_dn_s = diff_x_s[WIDTH-1:0];
            end
        end
    end

    // Position, step pulses, sticky error and previous-phase register
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r    <= 2'b00;
            value_r   <= '0;
            step_up_r <= 1'b0;
            step_dn_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            prev_r <= filt_r;
            if (illegal_s) begin
                err_r <= 1'b1;
            end else if (bus.clear_err) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            if (bus.load) begin
                value_r   <= bus.load_value;
                step_up_r <= 1'b0;
                step_dn_r <= 1'b0;
            end else if (cnt_up_s) begin
                value_r   <= nxt_up_s;
                step_up_r <= 1'b1;
                step_dn_r <= 1'b0;
            end else if (cnt_dn_s) begin
                value_r   <= nxt_dn_s;
                step_up_r <= 1'b0;
                step_dn_r <= 1'b1;
            end else begin
                step_up_r <= 1'b0;
                step_dn_r <= 1'b0;
            end
        end
    end

    assign bus.value   = value_r;
    assign bus.step_up = step_up_r;
    assign bus.step_dn = step_dn_r;
    assign bus.err     = err_r;

endmodule
